retire_free_list: RTL

Commit-side consumer of the reorder buffer's retirement stream, and the source of physical register tags for rename. It holds three pieces of state:
- the circular free list of physical register tags;
- the retirement map from architectural to physical registers;
- the architectural register file.

On each committed register write it updates the map and the register file, and recycles the previously mapped tag. On a branch flush it rolls back all speculative tag allocations in one cycle.

---
 rtl/retire_free_list_pkg.sv | 18 +
 rtl/retire_free_list_phys_free_fifo.sv | 102 ++++++++++
 rtl/retire_free_list.sv | 97 +++++++++
 3 files changed

// File: rtl/retire_free_list_pkg.sv
// retire_free_list_pkg
// Shared sizing parameters and types for the retirement-side free list.
// NUM_PHYS physical tags, NUM_ARCH architectural registers, XLEN data width,
// tag width log2(NUM_PHYS) and pointer width tag width + 1 (wrap bit).
package retire_free_list_pkg;

  localparam int NUM_PHYS      = 128;
  localparam int NUM_ARCH      = 32;
  localparam int XLEN          = 32;
  localparam int TAG_W         = $clog2(NUM_PHYS);
  localparam int PTR_W         = TAG_W + 1;
  localparam int ARCH_W        = $clog2(NUM_ARCH);
  localparam int NUM_INIT_FREE = NUM_PHYS - NUM_ARCH;

  typedef logic [TAG_W-1:0] phys_tag_t;
  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/retire_free_list_phys_free_fifo.sv
// phys_free_fifo
// Circular FIFO of free physical tags with a speculative head (rename side)
// and a retire head (commit side). A flush rolls the speculative head back
// to the retire head in one cycle.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_pop            rename takes the head tag (ignored when empty or flushing)
//   i_push/_tag      recycle a tag at the tail
//   i_retire         one allocation has committed; retire head advances
//   i_flush          roll head back to the (post-retire) retire head
//   o_head_tag       tag at the head
//   o_not_empty      registered count is non-zero
//   o_count          number of free tags
//   o_overflow       sticky: push seen while full
module phys_free_fifo
  import retire_free_list_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pop,
  input  logic             i_push,
  input  logic [TAG_W-1:0] i_push_tag,
  input  logic             i_retire,
  input  logic             i_flush,
  output logic [TAG_W-1:0] o_head_tag,
  output logic             o_not_empty,
  output logic [PTR_W-1:0] o_count,
  output logic             o_overflow
);

  localparam ptr_t FULL_COUNT = ptr_t'(NUM_PHYS);
  localparam ptr_t INIT_TAIL  = ptr_t'(NUM_INIT_FREE);

  phys_tag_t r_mem [NUM_PHYS];
  ptr_t      r_head;
  ptr_t      r_tail;
  ptr_t      r_retire_head;
  ptr_t      r_count;
  logic      r_overflow;

  logic w_pop_ok;
  logic w_push_ok;
  ptr_t w_head_nxt;
  ptr_t w_tail_nxt;
  ptr_t w_retire_head_nxt;
  ptr_t w_count_nxt;

  // Next-pointer and next-count computation; a flush uses post-commit pointers.
  always_comb begin
    w_pop_ok          = i_pop && (r_count != ptr_t'(0)) && !i_flush;
    w_push_ok         = i_push && (r_count != FULL_COUNT);
    w_tail_nxt        = r_tail + ptr_t'(w_push_ok);
    w_retire_head_nxt = r_retire_head + ptr_t'(i_retire);
    if (i_flush) begin
      w_head_nxt  = w_retire_head_nxt;
      w_count_nxt = w_tail_nxt - w_retire_head_nxt;
    end else begin
      w_head_nxt  = r_head + ptr_t'(w_pop_ok);
      w_count_nxt = r_count + ptr_t'(w_push_ok) - ptr_t'(w_pop_ok);
    end
  end

  // Pointer, count and overflow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head        <= ptr_t'(0);
      r_tail        <= INIT_TAIL;
      r_retire_head <= ptr_t'(0);
      r_count       <= INIT_TAIL;
      r_overflow    <= 1'b0;
    end else begin
      r_head        <= w_head_nxt;
      r_tail        <= w_tail_nxt;
      r_retire_head <= w_retire_head_nxt;
      r_count       <= w_count_nxt;
      if (i_push && (r_count == FULL_COUNT)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Tag storage: slots 0..95 start with tags 32..127, the rest are unused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        if (i < NUM_INIT_FREE) begin
          r_mem[i] <= phys_tag_t'(NUM_ARCH + i);
        end else begin
          r_mem[i] <= phys_tag_t'(0);
        end
      end
    end else if (w_push_ok) begin
      r_mem[r_tail[TAG_W-1:0]] <= i_push_tag;
    end
  end

  assign o_head_tag  = r_mem[r_head[TAG_W-1:0]];
  assign o_not_empty = (r_count != ptr_t'(0));
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;

endmodule

// File: rtl/retire_free_list.sv
// retire_free_list
// Commit-side consumer of the ROB retirement stream and tag source for rename.
// Holds the retirement map (arch -> phys), the architectural register file and
// the free-tag FIFO. An effective commit updates map and ARF and recycles the
// previously mapped tag; a flush discards all uncommitted allocations.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   i_alloc_valid / o_alloc_ready  rename tag handshake, o_alloc_phys = tag
//   i_commit_*                     one retiring ROB entry per cycle
//   i_flush                        mispredict rollback
//   i_rd_addr_a/b, o_rd_data_a/b   combinational ARF reads, x0 reads 0
//   o_free_count                   number of free tags
//   o_overflow_err                 sticky push-while-full flag
module retire_free_list
  import retire_free_list_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_alloc_valid,
  output logic              o_alloc_ready,
  output logic [TAG_W-1:0]  o_alloc_phys,
  input  logic              i_commit_valid,
  input  logic              i_commit_reg_write,
  input  logic [ARCH_W-1:0] i_commit_dest,
  input  logic [TAG_W-1:0]  i_commit_phys,
  input  logic [XLEN-1:0]   i_commit_value,
  input  logic              i_flush,
  input  logic [ARCH_W-1:0] i_rd_addr_a,
  input  logic [ARCH_W-1:0] i_rd_addr_b,
  output logic [XLEN-1:0]   o_rd_data_a,
  output logic [XLEN-1:0]   o_rd_data_b,
  output logic [PTR_W-1:0]  o_free_count,
  output logic              o_overflow_err
);

  phys_tag_t         r_map [NUM_ARCH];
  logic [XLEN-1:0]   r_arf [NUM_ARCH];

  logic              w_commit_eff;
  phys_tag_t         w_old_tag;

  // x0 is hard-wired, so commits to it must not touch any state.
  assign w_commit_eff = i_commit_valid && i_commit_reg_write &&
                        (i_commit_dest != {ARCH_W{1'b0}});
  assign w_old_tag    = r_map[i_commit_dest];

  phys_free_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_pop      (i_alloc_valid),
    .i_push     (w_commit_eff),
    .i_push_tag (w_old_tag),
    .i_retire   (w_commit_eff),
    .i_flush    (i_flush),
    .o_head_tag (o_alloc_phys),
    .o_not_empty(o_alloc_ready),
    .o_count    (o_free_count),
    .o_overflow (o_overflow_err)
  );

  // Retirement map: identity at reset, updated by effective commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        r_map[i] <= phys_tag_t'(i);
      end
    end else if (w_commit_eff) begin
      r_map[i_commit_dest] <= i_commit_phys;
    end
  end

  // Architectural register file: zero at reset, written by effective commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        r_arf[i] <= {XLEN{1'b0}};
      end
    end else if (w_commit_eff) begin
      r_arf[i_commit_dest] <= i_commit_value;
    end
  end

  // Read ports see pre-edge contents; no bypass from a same-cycle commit.
  always_comb begin
    if (i_rd_addr_a == {ARCH_W{1'b0}}) begin
      o_rd_data_a = {XLEN{1'b0}};
    end else begin
      o_rd_data_a = r_arf[i_rd_addr_a];
    end
    if (i_rd_addr_b == {ARCH_W{1'b0}}) begin
      o_rd_data_b = {XLEN{1'b0}};
    end else begin
      o_rd_data_b = r_arf[i_rd_addr_b];
    end
  end

endmodule
